encoder4to2_reg: RTL

//   Registered priority encoder: the inverse of the 2-to-4 decoder.

---
 rtl/encoder4to2_reg.sv | 122 ++++++++++++
 1 files changed

// File: rtl/encoder4to2_reg.sv
// encoder4to2_reg
//   Registered priority encoder with a valid/ready input and a one-entry
//   output register. It turns an N-line select vector (normally the one-hot
//   outputs of a 2-to-4 decoder) back into a binary index. It also flags
//   all-zero and multi-hot inputs, and keeps a saturating count of the
//   multi-hot inputs it has accepted.
//
// Handshake (valid/ready, both sides):
//   A transfer happens on a rising clk edge where valid && ready.
//   in_ready = (state == EMPTY) || out_ready. It is combinational and never
//   depends on in_valid. While out_valid is high and out_ready is low, the
//   result outputs stay stable. A simultaneous drain and accept reloads the
//   register on the same edge, so no bubble is inserted.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready input handshake for d
//   d[N-1:0]          input lines; d[i] high means line i is asserted
//   out_valid         result register holds a valid result (FSM == FULL)
//   out_ready         downstream takes the result this cycle
//   y[W-1:0]          index of the highest-numbered asserted line
//   zero              captured d had no line asserted
//   multi             captured d had two or more lines asserted
//   err_cnt[CNT_W-1:0] saturating count of accepted multi-hot inputs
module encoder4to2_reg #(
  parameter  int N     = 4,
  parameter  int CNT_W = 8,
  localparam int W     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     y,
  output logic             zero,
  output logic             multi,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       y_q, y_d;
  logic               zero_q, zero_d;
  logic               multi_q, multi_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               accept;
  logic               drain;
  logic [W-1:0]       y_enc;
  logic               zero_enc;
  logic               multi_enc;

  assign in_ready  = (state_q == EMPTY) || out_ready;
  assign out_valid = (state_q == FULL);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Combinational encode of the live input. The last matching line wins,
  // so y ends up as the highest-numbered asserted line.
  always_comb begin
    y_enc = '0;
    for (int i = 0; i < N; i++) begin
      if (d[i]) y_enc = W'(i);
    end
    zero_enc  = (d == '0);
    // Clearing the lowest set bit leaves something only if two or more
    // bits were set.
    multi_enc = |(d & (d - N'(1)));
  end

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    zero_d    = zero_q;
    multi_d   = multi_q;
    err_cnt_d = err_cnt_q;

    if (accept) begin
      y_d     = y_enc;
      zero_d  = zero_enc;
      multi_d = multi_enc;
      if (multi_enc && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (drain && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      y_q       <= '0;
      zero_q    <= 1'b0;
      multi_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      zero_q    <= zero_d;
      multi_q   <= multi_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign y       = y_q;
  assign zero    = zero_q;
  assign multi   = multi_q;
  assign err_cnt = err_cnt_q;

endmodule
